// File: rtl/fir_in_ctrl_if.sv
// Control bundle between the command layer, the upstream sample source and the
// FIR input stage. The sequencer uses the slave modport; the driving side uses master.
interface fir_in_ctrl_if #(
    parameter int DELAY_W = 6,
    parameter int SHIFT_W = 4,
    parameter int LEN_W   = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_mode;
    logic [DELAY_W-1:0] cfg_delay;
    logic [SHIFT_W-1:0] cfg_shift;
    logic [LEN_W-1:0]   cfg_len;
    logic               abort;
    logic               src_valid;
    logic               src_ready;
    logic               dp_valid;
    logic               dp_ready;
    logic               out_fire;
    logic               mode;
    logic [DELAY_W-1:0] delay;
    logic [SHIFT_W-1:0] shift;
    logic               flush;
    logic               busy;
    logic               done;
    logic               aborted;

    modport slave (
        input  cfg_valid, cfg_mode, cfg_delay, cfg_shift, cfg_len, abort,
               src_valid, dp_ready, out_fire,
        output cfg_ready, src_ready, dp_valid, mode, delay, shift, flush,
               busy, done, aborted
    );

    modport master (
        output cfg_valid, cfg_mode, cfg_delay, cfg_shift, cfg_len, abort,
               src_valid, dp_ready, out_fire,
        input  cfg_ready, src_ready, dp_valid, mode, delay, shift, flush,
               busy, done, aborted
    );
endinterface

// File: rtl/fir_in_ctrl.sv
// Frame sequencer for the FIR input stage: flush, settle, admit cfg_len samples,
// then wait for the same number of pops before reporting done (or aborted).
module fir_in_ctrl #(
    parameter int DELAY_W    = 6,
    parameter int SHIFT_W    = 4,
    parameter int LEN_W      = 16,
    parameter int FLUSH_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    fir_in_ctrl_if.slave bus
);
    localparam int MAX_CYC = (FLUSH_CYC > SETTLE_CYC) ? FLUSH_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_SETTLE, S_RUN, S_DRAIN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic               abort_pend_q, abort_pend_d;
    logic               mode_q, mode_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               flush_q, flush_d;
    logic               busy_q, busy_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;

    logic               src_ready;
    logic               sample_acc;
    logic               fire_cnt;

    // abort gates src_ready in the same cycle so no sample slips into an aborted frame
    assign src_ready  = (state_q == S_RUN) && bus.dp_ready && (in_cnt_q < len_q) && !bus.abort;
    assign sample_acc = bus.src_valid && src_ready;
    assign fire_cnt   = bus.out_fire && (out_cnt_q < len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cyc_cnt_q    <= '0;
            len_q        <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            mode_q       <= 1'b0;
            delay_q      <= '0;
            shift_q      <= '0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
            cfg_ready_q  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_cnt_q    <= cyc_cnt_d;
            len_q        <= len_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            abort_pend_q <= abort_pend_d;
            mode_q       <= mode_d;
            delay_q      <= delay_d;
            shift_q      <= shift_d;
            flush_q      <= flush_d;
            busy_q       <= busy_d;
            cfg_ready_q  <= cfg_ready_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_cnt_d    = cyc_cnt_q;
        len_d        = len_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        abort_pend_d = abort_pend_q;
        mode_d       = mode_q;
        delay_d      = delay_q;
        shift_d      = shift_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid && cfg_ready_q) begin
                    state_d      = S_FLUSH;
                    cyc_cnt_d    = '0;
                    abort_pend_d = 1'b0;
                    len_d        = bus.cfg_len;
                    mode_d       = bus.cfg_mode;
                    delay_d      = bus.cfg_delay;
                    shift_d      = bus.cfg_shift;
                end
            end
            S_FLUSH: begin
                in_cnt_d  = '0;
                out_cnt_d = '0;
                if (bus.abort) begin
                    abort_pend_d = 1'b1;
                end
                if (cyc_cnt_q == FLUSH_LAST) begin
                    cyc_cnt_d = '0;
                    if (abort_pend_d) begin
                        state_d      = S_IDLE;
                        abort_pend_d = 1'b0;
                        aborted_d    = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d      = S_FLUSH;
                    cyc_cnt_d    = '0;
                    abort_pend_d = 1'b1;
                end else if (cyc_cnt_q == SETTLE_LAST) begin
                    cyc_cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d      = S_FLUSH;
                    cyc_cnt_d    = '0;
                    abort_pend_d = 1'b1;
                end else begin
                    if (sample_acc) begin
                        in_cnt_d = in_cnt_q + LEN_W'(1);
                    end
                    if (fire_cnt) begin
                        out_cnt_d = out_cnt_q + LEN_W'(1);
                    end
                    if (in_cnt_d == len_q) begin
                        if (out_cnt_d == len_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d      = S_FLUSH;
                    cyc_cnt_d    = '0;
                    abort_pend_d = 1'b1;
                end else begin
                    if (fire_cnt) begin
                        out_cnt_d = out_cnt_q + LEN_W'(1);
                    end
                    if (out_cnt_d == len_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        flush_d     = (state_d == S_FLUSH);
        busy_d      = (state_d != S_IDLE);
        cfg_ready_d = (state_d == S_IDLE);
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.src_ready = src_ready;
    assign bus.dp_valid  = sample_acc;
    assign bus.mode      = mode_q;
    assign bus.delay     = delay_q;
    assign bus.shift     = shift_q;
    assign bus.flush     = flush_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_fir_in_ctrl.sv
// Self-checking bench for fir_in_ctrl: frame-end scoreboard plus per-scenario checks.
module tb_fir_in_ctrl;
    localparam int DW = 6;
    localparam int SW = 4;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_in_ctrl_if #(.DELAY_W(DW), .SHIFT_W(SW), .LEN_W(LW)) bus ();

    fir_in_ctrl #(
        .DELAY_W(DW), .SHIFT_W(SW), .LEN_W(LW), .FLUSH_CYC(2), .SETTLE_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit is_abort;
        int cyc;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    int   flush_n, sr_first, acc_n, acc_bad, dpv_bad, done_n, abort_n, last_fire;
    bit   echo_en = 1'b0;
    bit   bp_en   = 1'b0;
    logic man_fire = 1'b0;
    logic [3:0] pipe;
    logic acc_now;

    always @(posedge clk) cyc <= cyc + 1;

    // Observes every cycle at negedge; drives out_fire (echo or manual) and dp_ready.
    initial begin
        bus.out_fire = 1'b0;
        bus.dp_ready = 1'b1;
        pipe    = '0;
        dpv_bad = 0;
        forever begin
            @(negedge clk);
            acc_now = bus.src_valid && bus.src_ready;
            if (bus.flush === 1'b1) flush_n++;
            if (bus.src_ready === 1'b1 && sr_first < 0) sr_first = cyc;
            if (acc_now === 1'b1) begin
                acc_n++;
                if (bus.dp_ready !== 1'b1) acc_bad++;
            end
            if (bus.dp_valid !== acc_now) dpv_bad++;
            if (bus.done === 1'b1) done_n++;
            if (bus.aborted === 1'b1) abort_n++;
            if (bus.out_fire === 1'b1) last_fire = cyc;
            @(posedge clk);
            #2;
            pipe = rst ? 4'b0 : {pipe[2:0], acc_now & echo_en};
            bus.out_fire = echo_en ? pipe[3] : man_fire;
            bus.dp_ready = bp_en ? (cyc % 3 == 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic clr_obs();
        flush_n = 0; sr_first = -1; acc_n = 0; acc_bad = 0;
        done_n = 0; abort_n = 0; last_fire = -1;
    endtask

    task automatic send_cfg(input logic m, input logic [DW-1:0] d, input logic [SW-1:0] s,
                            input logic [LW-1:0] l, output int t, output logic rdy);
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = m;
        bus.cfg_delay = d;
        bus.cfg_shift = s;
        bus.cfg_len   = l;
        @(negedge clk);
        t   = cyc;
        rdy = bus.cfg_ready;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_end(output bit got, output bit ab, output int c);
        int i = 0;
        got = 1'b0; ab = 1'b0; c = -1;
        while (!got && i < 300) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.aborted === 1'b1) begin
                got = 1'b1;
                ab  = (bus.aborted === 1'b1);
                c   = cyc;
            end
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cfg_valid = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_delay = '0; bus.cfg_shift = '0;
        bus.cfg_len = '0; bus.abort = 1'b0; bus.src_valid = 1'b0;
        clr_obs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.cfg_ready, bus.src_ready, bus.dp_valid, bus.flush, bus.busy, bus.done, bus.aborted} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_ctl: got %b expected 0000000", {bus.cfg_ready, bus.src_ready, bus.dp_valid,
                     bus.flush, bus.busy, bus.done, bus.aborted});
        end
        n_checks++;
        if ({bus.mode, bus.delay, bus.shift} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_cfg: got %h expected 0", {bus.mode, bus.delay, bus.shift});
        end
        @(posedge clk); #1 rst = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: cfg_ready=%b busy=%b expected 1 0", bus.cfg_ready, bus.busy);
        end
        tick();
    endtask

    task automatic test_passthrough();
        int t, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); echo_en = 1'b1; bus.src_valid = 1'b1;
        send_cfg(1'b0, 6'd5, 4'd3, 16'd5, t, rdy);
        sb.push_back('{1'b0, t + 16, 5});
        @(negedge clk);
        n_checks++;
        if (rdy !== 1'b1 || bus.flush !== 1'b1 || bus.delay !== 6'd5 || bus.shift !== 4'd3) begin
            n_fail++;
            $display("FAIL pt_start: rdy=%b flush=%b delay=%0d shift=%0d expected 1 1 5 3",
                     rdy, bus.flush, bus.delay, bus.shift);
        end
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pt_end: got=%b aborted=%b cycle=%0d busy=%b expected 1 %b %0d 0",
                     got, ab, c, bus.busy, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (flush_n !== 2 || sr_first !== t + 7 || acc_n !== e.acc || c !== last_fire + 1) begin
            n_fail++;
            $display("FAIL pt_timing: flush=%0d first_rdy=%0d acc=%0d done=%0d expected 2 %0d %0d %0d",
                     flush_n, sr_first, acc_n, c, t + 7, e.acc, last_fire + 1);
        end
    endtask

    task automatic test_backpressure();
        int t, c, a, k; logic rdy; bit got, ab; exp_t e;
        clr_obs(); bp_en = 1'b1; echo_en = 1'b1; bus.src_valid = 1'b1;
        send_cfg(1'b1, 6'd12, 4'd7, 16'd4, t, rdy);
        a = t + 6; k = 0;
        while (k < 4) begin
            a++;
            if (a % 3 == 0) k++;
        end
        sb.push_back('{1'b0, a + 5, 4});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL bp_end: got=%b aborted=%b cycle=%0d expected 1 %b %0d", got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (acc_n !== e.acc || acc_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_accepts: acc=%0d bad=%0d expected %0d 0", acc_n, acc_bad, e.acc);
        end
        bp_en = 1'b0;
    endtask

    task automatic test_zero_len();
        int t, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); bus.src_valid = 1'b1;
        send_cfg(1'b0, 6'd1, 4'd1, 16'd0, t, rdy);
        sb.push_back('{1'b0, t + 7, 0});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL zl_end: got=%b aborted=%b cycle=%0d expected 1 %b %0d", got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (flush_n !== 2 || sr_first !== -1 || acc_n !== e.acc) begin
            n_fail++;
            $display("FAIL zl_obs: flush=%0d first_rdy=%0d acc=%0d expected 2 -1 0", flush_n, sr_first, acc_n);
        end
    endtask

    task automatic test_abort_run();
        int t, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); echo_en = 1'b1; bus.src_valid = 1'b1;
        send_cfg(1'b1, 6'd33, 4'd9, 16'd8, t, rdy);
        wait_until(t + 9);
        bus.abort = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.src_ready !== 1'b0 || acc_n !== 2) begin
            n_fail++;
            $display("FAIL ab_gate: src_ready=%b acc=%0d expected 0 2", bus.src_ready, acc_n);
        end
        tick();
        bus.abort = 1'b0;
        sb.push_back('{1'b1, t + 12, 2});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc || bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_end: got=%b aborted=%b cycle=%0d cfg_ready=%b expected 1 %b %0d 1",
                     got, ab, c, bus.cfg_ready, e.is_abort, e.cyc);
        end
        n_checks++;
        if ({bus.mode, bus.delay, bus.shift} !== {1'b1, 6'd33, 4'd9}) begin
            n_fail++;
            $display("FAIL ab_hold: got %h expected %h", {bus.mode, bus.delay, bus.shift}, {1'b1, 6'd33, 4'd9});
        end
        tick();
        n_checks++;
        if (flush_n !== 4 || acc_n !== e.acc || done_n !== 0) begin
            n_fail++;
            $display("FAIL ab_obs: flush=%0d acc=%0d done=%0d expected 4 %0d 0", flush_n, acc_n, done_n, e.acc);
        end
    endtask

    task automatic test_abort_idle_flush();
        int t, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); echo_en = 1'b1; bus.src_valid = 1'b1;
        bus.abort = 1'b1;
        send_cfg(1'b0, 6'd7, 4'd2, 16'd3, t, rdy);
        bus.abort = 1'b0;
        sb.push_back('{1'b0, t + 14, 3});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (rdy !== 1'b1 || !got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL ai_end: rdy=%b got=%b aborted=%b cycle=%0d expected 1 1 %b %0d",
                     rdy, got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (abort_n !== 0 || acc_n !== e.acc) begin
            n_fail++;
            $display("FAIL ai_obs: aborted=%0d acc=%0d expected 0 %0d", abort_n, acc_n, e.acc);
        end
        clr_obs();
        send_cfg(1'b1, 6'd9, 4'd4, 16'd3, t, rdy);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        sb.push_back('{1'b1, t + 3, 0});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL af_end: got=%b aborted=%b cycle=%0d expected 1 %b %0d", got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (flush_n !== 2 || acc_n !== e.acc || done_n !== 0) begin
            n_fail++;
            $display("FAIL af_obs: flush=%0d acc=%0d done=%0d expected 2 %0d 0", flush_n, acc_n, done_n, e.acc);
        end
    endtask

    task automatic test_reset_drain();
        int t, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); echo_en = 1'b0; man_fire = 1'b0; bus.src_valid = 1'b1;
        send_cfg(1'b1, 6'd44, 4'd13, 16'd6, t, rdy);
        wait_until(t + 13);
        man_fire = 1'b1;
        tick();
        tick();
        man_fire = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || acc_n !== 6 || bus.src_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_pre: busy=%b acc=%0d src_ready=%b expected 1 6 0", bus.busy, acc_n, bus.src_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.cfg_ready, bus.src_ready, bus.dp_valid, bus.flush, bus.busy, bus.done, bus.aborted,
             bus.mode, bus.delay, bus.shift} !== 18'd0) begin
            n_fail++;
            $display("FAIL rd_async: got %h expected 0", {bus.cfg_ready, bus.src_ready, bus.dp_valid, bus.flush,
                     bus.busy, bus.done, bus.aborted, bus.mode, bus.delay, bus.shift});
        end
        @(posedge clk); #1 rst = 1'b0;
        man_fire = 1'b1;
        tick();
        man_fire = 1'b0;
        n_checks++;
        if (done_n !== 0 || abort_n !== 0) begin
            n_fail++;
            $display("FAIL rd_pulse: done=%0d aborted=%0d expected 0 0", done_n, abort_n);
        end
        clr_obs(); echo_en = 1'b1;
        send_cfg(1'b0, 6'd2, 4'd1, 16'd2, t, rdy);
        sb.push_back('{1'b0, t + 13, 2});
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (rdy !== 1'b1 || !got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL rd_fresh: rdy=%b got=%b aborted=%b cycle=%0d expected 1 1 %b %0d",
                     rdy, got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (acc_n !== e.acc || flush_n !== 2) begin
            n_fail++;
            $display("FAIL rd_fresh_obs: acc=%0d flush=%0d expected %0d 2", acc_n, flush_n, e.acc);
        end
    endtask

    task automatic test_back_to_back();
        int t, t2, c; logic rdy; bit got, ab; exp_t e;
        clr_obs(); echo_en = 1'b1; bus.src_valid = 1'b1;
        send_cfg(1'b0, 6'd3, 4'd5, 16'd1, t, rdy);
        sb.push_back('{1'b0, t + 12, 1});
        wait_until(t + 12);
        bus.cfg_valid = 1'b1; bus.cfg_mode = 1'b1; bus.cfg_delay = 6'd63; bus.cfg_shift = 4'd15;
        bus.cfg_len = 16'd1;
        @(negedge clk);
        e = sb.pop_front();
        t2 = cyc;
        n_checks++;
        if (bus.done !== !e.is_abort || bus.cfg_ready !== 1'b1 || t2 !== e.cyc) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b cfg_ready=%b cycle=%0d expected 1 1 %0d", bus.done, bus.cfg_ready, t2, e.cyc);
        end
        sb.push_back('{1'b0, t2 + 12, 1});
        tick();
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.flush !== 1'b1 || {bus.mode, bus.delay, bus.shift} !== {1'b1, 6'd63, 4'd15}) begin
            n_fail++;
            $display("FAIL b2b_load: flush=%b cfg=%h expected 1 %h", bus.flush,
                     {bus.mode, bus.delay, bus.shift}, {1'b1, 6'd63, 4'd15});
        end
        wait_end(got, ab, c);
        e = sb.pop_front();
        n_checks++;
        if (!got || ab !== e.is_abort || c !== e.cyc) begin
            n_fail++;
            $display("FAIL b2b_second: got=%b aborted=%b cycle=%0d expected 1 %b %0d", got, ab, c, e.is_abort, e.cyc);
        end
        tick();
        n_checks++;
        if (dpv_bad !== 0) begin
            n_fail++;
            $display("FAIL dp_valid: %0d cycles differ from src_valid&src_ready, expected 0", dpv_bad);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_backpressure();
        test_zero_len();
        test_abort_run();
        test_abort_idle_flush();
        test_reset_drain();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
